// File: rtl/pipeline_pkg.sv
// Shared definitions for the 16-bit pipeline: opcodes, data width and the
// MEM-stage handshake state encoding.
package pipeline_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LD  = 4'b0100;
  localparam logic [3:0] OP_ST  = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b0110;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/mem_handshake_fsm.sv
// Data-memory req/ack handshake: owns the request registers, the wait-cycle
// counter, the upstream stall and the timeout abort.
module mem_handshake_fsm #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);
  import pipeline_pkg::*;

  localparam logic       TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [0:0] state;
  logic [7:0] counter;

  // Completion and abort qualifiers; an ack in the last allowed cycle wins.
  always_comb begin
    busy    = (state == WAIT);
    done    = busy && mem_ack;
    timeout = TIMEOUT_EN && busy && !mem_ack && (counter == TIMEOUT_LAST);
  end

  // Stall is combinational so upstream releases in the same cycle as ack/abort.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      stall = 1'b0;
    end else begin
      case (state)
        IDLE:    stall = start;
        WAIT:    stall = !mem_ack && !timeout;
        default: stall = 1'b0;
      endcase
    end
  end

  // Handshake state, wait counter and request registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {DATA_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WAIT;
            counter   <= 8'd0;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= addr;
            mem_wdata <= wdata;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (mem_ack || timeout) begin
            state     <= IDLE;
            counter   <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {DATA_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
          end else begin
            counter <= counter + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores through the handshake FSM, resolves BEQ and
// drives the MEM/WB register consumed by write-back.
module mem_access_stage #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        opcode,
  input  logic              aluZERO,
  input  logic [DATA_W-1:0] aluRESULT,
  input  logic [DATA_W-1:0] read_data2,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [3:0]        wb_opcode,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic              branch_taken,
  output logic              mem_error
);
  import pipeline_pkg::*;

  logic is_mem;
  logic busy;
  logic done;
  logic timeout;

  assign is_mem = is_mem_op(opcode);

  mem_handshake_fsm #(
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clock    (clock),
    .reset    (reset),
    .start    (is_mem),
    .is_store (opcode == OP_ST),
    .addr     (aluRESULT),
    .wdata    (read_data2),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata)
  );

  // MEM/WB register: non-memory ops pass through, memory ops retire on ack,
  // every other cycle is a bubble so each instruction yields one entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wb_valid      <= 1'b0;
      wb_opcode     <= 4'd0;
      wb_alu_result <= {DATA_W{1'b0}};
      wb_mem_data   <= {DATA_W{1'b0}};
      branch_taken  <= 1'b0;
      mem_error     <= 1'b0;
    end else begin
      if (!busy && !is_mem) begin
        wb_valid      <= (opcode != OP_NOP);
        wb_opcode     <= opcode;
        wb_alu_result <= aluRESULT;
        wb_mem_data   <= {DATA_W{1'b0}};
      end else if (done) begin
        wb_valid      <= 1'b1;
        wb_opcode     <= opcode;
        wb_alu_result <= aluRESULT;
        wb_mem_data   <= (opcode == OP_LD) ? mem_rdata : {DATA_W{1'b0}};
      end else begin
        wb_valid      <= 1'b0;
        wb_opcode     <= 4'd0;
        wb_alu_result <= {DATA_W{1'b0}};
        wb_mem_data   <= {DATA_W{1'b0}};
      end
      branch_taken <= !busy && (opcode == OP_BEQ) && aluZERO;
      mem_error    <= timeout;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed literal checks followed by
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_access_stage;

  localparam int TO = 4;
  localparam logic [3:0] T_NOP = 4'h0;
  localparam logic [3:0] T_ADD = 4'h1;
  localparam logic [3:0] T_LD  = 4'h4;
  localparam logic [3:0] T_ST  = 4'h5;
  localparam logic [3:0] T_BEQ = 4'h6;

  logic        clock;
  logic        reset;
  logic [3:0]  opcode;
  logic        aluZERO;
  logic [15:0] aluRESULT;
  logic [15:0] read_data2;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [3:0]  wb_opcode;
  logic [15:0] wb_alu_result;
  logic [15:0] wb_mem_data;
  logic        branch_taken;
  logic        mem_error;

  mem_access_stage #(.DATA_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .aluZERO(aluZERO),
    .aluRESULT(aluRESULT), .read_data2(read_data2), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_alu_result(wb_alu_result),
    .wb_mem_data(wb_mem_data), .branch_taken(branch_taken), .mem_error(mem_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;
  logic last_stall = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding access at most, tracked as a transaction
  // with its elapsed wait count; expectations are what the outputs must hold.
  logic        m_busy = 1'b0;
  int          m_waited = 0;
  logic        e_req = 1'b0, e_we = 1'b0, e_wb_valid = 1'b0, e_branch = 1'b0, e_err = 1'b0;
  logic [15:0] e_addr = 16'h0, e_wdata = 16'h0, e_wb_alu = 16'h0, e_wb_mem = 16'h0;
  logic [3:0]  e_wb_op = 4'h0;

  function automatic logic is_mem(input logic [3:0] op);
    return (op == T_LD) || (op == T_ST);
  endfunction

  function automatic logic model_stall();
    if (!reset) return 1'b0;
    if (!m_busy) return is_mem(opcode);
    return !(mem_ack || (TO != 0 && m_waited == TO - 1));
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_busy <= 1'b0; m_waited <= 0;
      e_req <= 1'b0; e_we <= 1'b0; e_addr <= 16'h0; e_wdata <= 16'h0;
      e_wb_valid <= 1'b0; e_wb_op <= 4'h0; e_wb_alu <= 16'h0; e_wb_mem <= 16'h0;
      e_branch <= 1'b0; e_err <= 1'b0;
    end else begin
      e_wb_valid <= 1'b0; e_wb_op <= 4'h0; e_wb_alu <= 16'h0; e_wb_mem <= 16'h0;
      e_branch <= 1'b0; e_err <= 1'b0;
      if (!m_busy) begin
        if (is_mem(opcode)) begin
          m_busy <= 1'b1; m_waited <= 0;
          e_req <= 1'b1; e_we <= (opcode == T_ST); e_addr <= aluRESULT; e_wdata <= read_data2;
        end else begin
          e_wb_valid <= (opcode != T_NOP); e_wb_op <= opcode; e_wb_alu <= aluRESULT;
          e_branch <= (opcode == T_BEQ) && aluZERO;
        end
      end else if (mem_ack) begin
        m_busy <= 1'b0;
        e_req <= 1'b0; e_we <= 1'b0; e_addr <= 16'h0; e_wdata <= 16'h0;
        e_wb_valid <= 1'b1; e_wb_op <= opcode; e_wb_alu <= aluRESULT;
        e_wb_mem <= (opcode == T_LD) ? mem_rdata : 16'h0;
      end else if (TO != 0 && m_waited == TO - 1) begin
        m_busy <= 1'b0;
        e_req <= 1'b0; e_we <= 1'b0; e_addr <= 16'h0; e_wdata <= 16'h0;
        e_err <= 1'b1;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, mid-cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("stall", {15'h0, stall}, {15'h0, model_stall()});
      chk("mem_req", {15'h0, mem_req}, {15'h0, e_req});
      chk("mem_we", {15'h0, mem_we}, {15'h0, e_we});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("wb_valid", {15'h0, wb_valid}, {15'h0, e_wb_valid});
      chk("wb_opcode", {12'h0, wb_opcode}, {12'h0, e_wb_op});
      chk("wb_alu_result", wb_alu_result, e_wb_alu);
      chk("wb_mem_data", wb_mem_data, e_wb_mem);
      chk("branch_taken", {15'h0, branch_taken}, {15'h0, e_branch});
      chk("mem_error", {15'h0, mem_error}, {15'h0, e_err});
      last_stall <= model_stall();
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; opcode = T_LD; aluZERO = 1'b0; aluRESULT = 16'h0040;
    read_data2 = 16'h0000; mem_ack = 1'b0; mem_rdata = 16'h0000;

    // Reset held with a load presented: no stall, outputs cleared.
    cyc(); chk_en = 1'b1;
    cyc(); mid();
    chk("dir_rst_stall", {15'h0, stall}, 16'h0000);
    chk("dir_rst_req", {15'h0, mem_req}, 16'h0000);
    chk("dir_rst_wbv", {15'h0, wb_valid}, 16'h0000);
    cyc(); reset = 1'b1; mid();
    chk("dir_rel_stall", {15'h0, stall}, 16'h0001);

    // Load to 0x0040 acked in the first wait cycle.
    cyc(); mem_ack = 1'b1; mem_rdata = 16'hBEEF; mid();
    chk("dir_ld_req", {15'h0, mem_req}, 16'h0001);
    chk("dir_ld_addr", mem_addr, 16'h0040);
    chk("dir_ld_ackstall", {15'h0, stall}, 16'h0000);
    cyc(); mem_ack = 1'b0; opcode = T_ADD; aluRESULT = 16'h1234; mid();
    chk("dir_ld_reqdrop", {15'h0, mem_req}, 16'h0000);
    chk("dir_ld_wbv", {15'h0, wb_valid}, 16'h0001);
    chk("dir_ld_data", wb_mem_data, 16'hBEEF);
    chk("dir_add_stall", {15'h0, stall}, 16'h0000);

    // Store of 0x00AA to 0x0010, ack coinciding with the last allowed wait cycle.
    cyc(); opcode = T_ST; aluRESULT = 16'h0010; read_data2 = 16'h00AA; mid();
    chk("dir_add_alu", wb_alu_result, 16'h1234);
    chk("dir_add_mem", wb_mem_data, 16'h0000);
    chk("dir_st_stall", {15'h0, stall}, 16'h0001);
    cyc(); mid();
    chk("dir_st_we", {15'h0, mem_we}, 16'h0001);
    chk("dir_st_wdata", mem_wdata, 16'h00AA);
    cyc(); cyc(); cyc(); mem_ack = 1'b1; mid();
    chk("dir_st_we_held", {15'h0, mem_we}, 16'h0001);
    chk("dir_st_ackstall", {15'h0, stall}, 16'h0000);
    cyc(); mem_ack = 1'b0; opcode = T_BEQ; aluZERO = 1'b1; mid();
    chk("dir_st_wbv", {15'h0, wb_valid}, 16'h0001);
    chk("dir_st_op", {12'h0, wb_opcode}, 16'h0005);
    chk("dir_st_noerr", {15'h0, mem_error}, 16'h0000);

    // BEQ taken then not taken.
    cyc(); aluZERO = 1'b0; mid();
    chk("dir_beq_taken", {15'h0, branch_taken}, 16'h0001);
    cyc(); opcode = T_LD; aluRESULT = 16'h0080; mid();
    chk("dir_beq_not", {15'h0, branch_taken}, 16'h0000);

    // Load with no ack: abort after TO wait cycles, late ack ignored.
    cyc(); cyc(); cyc(); mid();
    chk("dir_to_stall", {15'h0, stall}, 16'h0001);
    cyc(); mid();
    chk("dir_to_release", {15'h0, stall}, 16'h0000);
    cyc(); opcode = T_NOP; mem_ack = 1'b1; mid();
    chk("dir_to_err", {15'h0, mem_error}, 16'h0001);
    chk("dir_to_wbv", {15'h0, wb_valid}, 16'h0000);
    cyc(); mem_ack = 1'b0; opcode = T_LD; mid();
    chk("dir_to_errpulse", {15'h0, mem_error}, 16'h0000);

    // Reset mid-wait aborts the access.
    cyc(); reset = 1'b0; mid();
    chk("dir_rw_req", {15'h0, mem_req}, 16'h0001);
    cyc(); reset = 1'b1; opcode = T_NOP; mid();
    chk("dir_rw_reqdrop", {15'h0, mem_req}, 16'h0000);
    chk("dir_rw_stall", {15'h0, stall}, 16'h0000);

    // Randomized pipeline traffic; inputs only advance when not stalled.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      reset = ($urandom_range(0, 63) != 0);
      if (!last_stall) begin
        case ($urandom_range(0, 5))
          0:       opcode = T_NOP;
          1:       opcode = T_LD;
          2:       opcode = T_ST;
          3:       opcode = T_BEQ;
          4:       opcode = T_ADD;
          default: opcode = 4'($urandom_range(0, 15));
        endcase
        aluZERO    = 1'($urandom_range(0, 1));
        aluRESULT  = 16'($urandom);
        read_data2 = 16'($urandom);
      end
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = 16'($urandom);
    end

    mid(); mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
